// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the PSR datapath.
package pipe_ctrl_pkg;

   localparam int unsigned STAGES_DEF   = 3;
   localparam int unsigned REG_BITS_DEF = 4;
   localparam int unsigned N_SRC        = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      IMM   = 3'd2,
      SHIFT = 3'd3,
      FLUSH = 3'd4
   } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the sequencing controller (master) and the PSR datapath (slave).
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned STAGES   = STAGES_DEF,
   parameter int unsigned REG_BITS = REG_BITS_DEF
);

   logic                         run;
   logic                         two_word;
   logic [N_SRC*REG_BITS-1:0]    src_addr;
   logic [N_SRC-1:0]             src_vld;
   logic [STAGES*REG_BITS-1:0]   dst_addr;
   logic [STAGES-1:0]            dst_wr;
   logic                         branch_taken;
   logic [STAGES-1:0]            c_left;
   logic [STAGES-1:0]            c_right;
   logic                         ld_ri;
   logic [STAGES-1:0]            bubble;
   logic                         psr_clr_n;
   logic                         pc_en;
   logic                         stall;

   modport master (
      input  run, two_word, src_addr, src_vld, dst_addr, dst_wr, branch_taken,
      output c_left, c_right, ld_ri, bubble, psr_clr_n, pc_en, stall
   );

   modport slave (
      output run, two_word, src_addr, src_vld, dst_addr, dst_wr, branch_taken,
      input  c_left, c_right, ld_ri, bubble, psr_clr_n, pc_en, stall
   );

endinterface

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Read-after-write detector: flags a source operand still pending in PSR 1..STAGES-1.
module hazard_cmp
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned STAGES   = STAGES_DEF,
   parameter int unsigned REG_BITS = REG_BITS_DEF
) (
   input  logic [N_SRC*REG_BITS-1:0]  src_addr,
   input  logic [N_SRC-1:0]           src_vld,
   input  logic [STAGES*REG_BITS-1:0] dst_addr,
   input  logic [STAGES-1:0]          dst_wr,
   output logic                       hazard
);

   // PSR0 is excluded: its destination is written back before the new operand is read.
   always_comb begin
      hazard = 1'b0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (src_vld[i] && dst_wr[k] &&
                (src_addr[i*REG_BITS +: REG_BITS] == dst_addr[k*REG_BITS +: REG_BITS]))
               hazard = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: two-phase load/shift, Ri load, RAW stall, branch flush.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned STAGES   = STAGES_DEF,
   parameter int unsigned REG_BITS = REG_BITS_DEF
) (
   input  logic        clk,
   input  logic        clr,
   pipe_ctrl_if.master bus
);

   state_t             state, state_nxt;
   logic               flush_done, flush_done_nxt;
   logic               hazard;
   logic               psr_clr_q;
   logic [STAGES-1:0]  c_left, c_right, bubble;
   logic               ld_ri, pc_en, stall;

   hazard_cmp #(.STAGES(STAGES), .REG_BITS(REG_BITS)) u_hazard (
      .src_addr (bus.src_addr),
      .src_vld  (bus.src_vld),
      .dst_addr (bus.dst_addr),
      .dst_wr   (bus.dst_wr),
      .hazard   (hazard)
   );

   // State, flush marker and PSR clear register; clr forces IDLE from any state.
   always_ff @(posedge clk) begin
      psr_clr_q <= ~clr;
      if (clr) begin
         state      <= IDLE;
         flush_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         flush_done <= flush_done_nxt;
      end
   end

   // Next-state and strobe decode from the registered state (plus hazard in LOAD).
   always_comb begin
      state_nxt      = state;
      flush_done_nxt = flush_done;
      c_left         = '0;
      c_right        = '0;
      bubble         = '0;
      ld_ri          = 1'b0;
      pc_en          = 1'b0;
      stall          = 1'b0;
      case (state)
         IDLE: begin
            if (bus.run) state_nxt = LOAD;
         end
         LOAD: begin
            c_left = '1;
            if (hazard) begin
               c_left[0] = 1'b0;
               bubble[1] = 1'b1;
               stall     = 1'b1;
               state_nxt = SHIFT;
            end else begin
               pc_en     = 1'b1;
               state_nxt = bus.two_word ? IMM : SHIFT;
            end
         end
         IMM: begin
            ld_ri     = 1'b1;
            pc_en     = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            c_right        = '1;
            flush_done_nxt = 1'b0;
            if (bus.branch_taken && !flush_done) state_nxt = FLUSH;
            else if (bus.run)                    state_nxt = LOAD;
            else                                 state_nxt = IDLE;
         end
         FLUSH: begin
            bubble[0]      = 1'b1;
            bubble[1]      = 1'b1;
            pc_en          = 1'b1;
            flush_done_nxt = 1'b1;
            state_nxt      = SHIFT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.c_left    = c_left;
   assign bus.c_right   = c_right;
   assign bus.bubble    = bubble;
   assign bus.ld_ri     = ld_ri;
   assign bus.pc_en     = pc_en;
   assign bus.stall     = stall;
   assign bus.psr_clr_n = psr_clr_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected strobes queued per cycle, checked mid-cycle.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic clr = 1'b1;

   pipe_ctrl_if #(.STAGES(3), .REG_BITS(4)) bus ();

   pipe_ctrl #(.STAGES(3), .REG_BITS(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] cl;
      logic [2:0] cr;
      logic [2:0] bub;
      logic       ri;
      logic       pcn;
      logic       pc;
      logic       st;
   } exp_t;

   exp_t sb[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Queue the expected strobes for the cycle just driven, sample mid-cycle, advance.
   task automatic step(input string tag,
                       input logic [2:0] cl, input logic [2:0] cr, input logic [2:0] bub,
                       input logic ri, input logic pcn, input logic pc, input logic st);
      exp_t e;
      e = '{cl: cl, cr: cr, bub: bub, ri: ri, pcn: pcn, pc: pc, st: st};
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, ".c_left"},    32'(bus.c_left),    32'(e.cl));
         check({tag, ".c_right"},   32'(bus.c_right),   32'(e.cr));
         check({tag, ".bubble"},    32'(bus.bubble),    32'(e.bub));
         check({tag, ".ld_ri"},     32'(bus.ld_ri),     32'(e.ri));
         check({tag, ".psr_clr_n"}, 32'(bus.psr_clr_n), 32'(e.pcn));
         check({tag, ".pc_en"},     32'(bus.pc_en),     32'(e.pc));
         check({tag, ".stall"},     32'(bus.stall),     32'(e.st));
      end
      @(negedge clk);
   endtask

   initial begin
      bus.run          = 1'b0;
      bus.two_word     = 1'b0;
      bus.src_addr     = '0;
      bus.src_vld      = '0;
      bus.dst_addr     = '0;
      bus.dst_wr       = '0;
      bus.branch_taken = 1'b0;
      @(negedge clk);

      // reset held for two edges, then release with run
      step("rst",      3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      clr = 1'b0; bus.run = 1'b1;
      step("rst_rel",  3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      step("load0",    3'b111, 3'b000, 3'b000, 0, 1, 1, 0);

      // steady single-word flow
      step("flow_s0",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
      step("flow_l1",  3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      step("flow_s1",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
      step("flow_l2",  3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      step("flow_s2",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);

      // two-word instruction
      bus.two_word = 1'b1;
      step("tw_load",  3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      bus.two_word = 1'b0;
      step("tw_imm",   3'b000, 3'b000, 3'b000, 1, 1, 1, 0);
      step("tw_shift", 3'b000, 3'b111, 3'b000, 0, 1, 0, 0);

      // RAW hazard on PSR1 with a two-word instruction: IMM is skipped
      bus.two_word = 1'b1;
      bus.src_addr = 8'h05; bus.src_vld = 2'b01;
      bus.dst_addr = 12'h050; bus.dst_wr = 3'b010;
      step("haz1",     3'b110, 3'b000, 3'b010, 0, 1, 0, 1);
      step("haz1_sh",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
      bus.dst_wr = 3'b000;
      step("retry",    3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      bus.two_word = 1'b0;
      step("retry_imm",3'b000, 3'b000, 3'b000, 1, 1, 1, 0);

      // taken branch, held high across the flush
      bus.branch_taken = 1'b1;
      step("br_shift", 3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
      step("flush",    3'b000, 3'b000, 3'b011, 0, 1, 1, 0);
      step("fl_shift", 3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
      bus.branch_taken = 1'b0;

      // match against PSR0 only is not a hazard
      bus.src_addr = 8'h05; bus.src_vld = 2'b01;
      bus.dst_addr = 12'h005; bus.dst_wr = 3'b001;
      step("psr0_ok",  3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      step("psr0_sh",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);

      // second source against the last PSR
      bus.src_addr = 8'h90; bus.src_vld = 2'b10;
      bus.dst_addr = 12'h900; bus.dst_wr = 3'b100;
      step("haz2",     3'b110, 3'b000, 3'b010, 0, 1, 0, 1);
      step("haz2_sh",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);

      // matching address but source not valid
      bus.src_vld = 2'b00; bus.two_word = 1'b1;
      step("novld",    3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      bus.src_addr = '0; bus.dst_addr = '0; bus.dst_wr = '0; bus.two_word = 1'b0;

      // clr during IMM
      clr = 1'b1;
      step("clr_imm",  3'b000, 3'b000, 3'b000, 1, 1, 1, 0);
      clr = 1'b0; bus.run = 1'b0;
      step("clr_idle", 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      bus.run = 1'b1;
      step("idle_run", 3'b000, 3'b000, 3'b000, 0, 1, 0, 0);

      // run dropped mid-sequence
      bus.run = 1'b0;
      step("stop_ld",  3'b111, 3'b000, 3'b000, 0, 1, 1, 0);
      step("stop_sh",  3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
      step("stop_idl", 3'b000, 3'b000, 3'b000, 0, 1, 0, 0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
